imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//  Responder end of the IF<->IMEM interface. Accepts instruction fetch requests from the fetch stage.
//  Services them over a simple single-outstanding req/ack backing bus (ROM/flash/SRAM bridge).
//  Returns word + one-cycle ack. A one-entry tagged response buffer decouples bus latency from fetch stalls.
// PARAMETERS
//  ADDR_W  32  fetch/bus address width (= XLEN)
//  DATA_W  32  instruction word width
// PORTS
//  clk          in   1            clock, all state on posedge
//  rst          in   1            synchronous reset, active-high
//  if2mem_i     in   type_if2imem_s  .addr (ADDR_W), .req; from fetch
//  mem2if_o     out  type_imem2if_s  .r_data (DATA_W), .ack; to fetch
//  imem_flush_i in   1            invalidate buffer (fence.i / CSR redirect)
//  bus_req_o    out  1            backing bus request, held until bus_ack_i
//  bus_addr_o   out  ADDR_W       word-aligned bus address, stable while bus_req_o
//  bus_ack_i    in   1            one-cycle response strobe, qualifies bus_rdata_i
//  bus_rdata_i  in   DATA_W       bus read data
// BEHAVIOUR
//  - Reset: state=IDLE, buf_valid=0, buf_tag=0, buf_data=0, bus_req_o=0, bus_addr_o=0; mem2if_o.ack=0, r_data=0.
//  - Aligned address: a_al={addr[ADDR_W-1:2],2'b00}. Misaligned addr served as a_al; fetch raises its own exception.
//  - Hit (comb): ack = req & buf_valid & (buf_tag==a_al); r_data = buf_data (registered). No comb path from bus_* to mem2if_o.
//  - req=0 (kill): ack=0. In-flight bus transfer is never aborted; it completes and is written with its own tag.
//  - Single outstanding bus transfer. bus_req_o/bus_addr_o are registered, deasserted the cycle after bus_ack_i.
//  - Bus return: buf_data<=bus_rdata_i, buf_tag<=inflight addr, buf_valid<=1. Visible to fetch next cycle.
//  - Miss latency, zero-wait bus: req seen T, bus_req_o T+1, bus_ack_i T+1, ack T+2.
//  - FSM states:
//    IDLE    : req & miss -> launch a_al, DEMAND.
//    DEMAND  : bus_ack_i -> IDLE (fill). If a_al changes mid-flight -> DRAIN.
//    DRAIN   : bus_ack_i -> fill (stale tag), then IDLE. IDLE relaunches current a_al next cycle if still miss.
//    PF_WAIT : prefetch in flight, see CONFIGURATION.
//  - Ack consumes the entry: buf_valid<=0 on the cycle after ack. No double-ack of the same fetch.
//  - imem_flush_i: buf_valid<=0 next cycle. If a transfer is in flight -> DRAIN, fill discarded (valid stays 0).
//    Flush has priority over a same-cycle bus fill and over ack. ack is forced 0 that cycle.
//  - Same-cycle hit and bus_ack_i cannot occur in DEMAND: miss implies no hit. In PF_WAIT, hit on the old entry is honoured first.
//  - Mid-operation reset: abandons FSM. Bus side is on the same reset; a bus_ack_i received in IDLE is ignored.
// CONFIGURATION
//  IMEM_PREFETCH_EN defined:
//    - On ack of A, if A != top word (all-ones[ADDR_W-1:2]), launch A+4 the next cycle -> PF_WAIT.
//    - Fill makes the entry A+4. Sequential stream then sustains 1 instr / (bus latency+1) and hides ack->launch.
//    - In PF_WAIT, a fetch of a_al != A+4 -> DRAIN, then demand fetch.
//  IMEM_PREFETCH_EN undefined:
//    - PF_WAIT unreachable and removed. After ack, FSM waits in IDLE for the next miss.
//  Interface and ack/data timing rules are identical in both builds.
// STRUCTURE
//  - Shared package/defs (pcore_interface_defs.svh):
//    - type_imem_resp_state_e {IMEM_IDLE, IMEM_DEMAND, IMEM_PF_WAIT, IMEM_DRAIN}
//    - IMEM_WORD_STRIDE=4
//    - existing type_if2imem_s / type_imem2if_s, unchanged.
//  - Sub-module imem_resp_buf: tag/data/valid registers, fill/invalidate/consume controls, hit comparator.
//  - FSM and bus driver live in imem_responder.
// TESTING
//  1. Zero-wait bus, req=1 addr=0x0000_0100, mem[0x100]=0x0000_0013 -> bus_req_o at T+1 addr 0x100, ack+r_data=0x13 at T+2, ack exactly 1 cycle.
//  2. Bus 3 wait states, fetch changes addr 0x100->0x200 at T+2 -> no ack for 0x100, DRAIN, second bus_addr_o=0x200, ack with mem[0x200].
//  3. req=0 during fill of 0x300, then req=1 addr 0x300 -> ack next cycle with no new bus_req_o (buffer hit).
//  4. imem_flush_i same cycle as bus_ack_i for 0x400 -> no ack for 0x400; refetch issued, ack after full miss latency.
//  5. IMEM_PREFETCH_EN: stream 0x0,0x4,0x8, zero-wait bus -> bus_addr_o sequence 0x0,0x4,0x8, one ack every 2 cycles; addr 0xFFFF_FFFC -> no prefetch launched.
//  6. rst pulsed while DEMAND -> next cycle all outputs 0, state IDLE, late bus_ack_i ignored.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// -----------------------------------------------------------------------------
// imem_responder_pkg
// Shared definitions for the IF<->IMEM responder:
//   - address/data widths and the word stride used for sequential prefetch
//   - fetch-side request/response structs (type_if2imem_s / type_imem2if_s)
//   - responder FSM state encoding
//   - address helpers (word alignment, top-word detection)
// The optional sequential prefetcher is enabled with `define IMEM_PREFETCH_EN.
// -----------------------------------------------------------------------------
package imem_responder_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] IMEM_WORD_STRIDE = 32'd4;

  // Fetch stage -> IMEM request
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              req;
  } type_if2imem_s;

  // IMEM -> fetch stage response
  typedef struct packed {
    logic [DATA_W-1:0] r_data;
    logic              ack;
  } type_imem2if_s;

  typedef enum logic [1:0] {
    IMEM_IDLE    = 2'd0,
    IMEM_DEMAND  = 2'd1,
    IMEM_PF_WAIT = 2'd2,
    IMEM_DRAIN   = 2'd3
  } type_imem_resp_state_e;

  // Clear the byte offset; misaligned fetches are served as the containing word.
  function automatic logic [ADDR_W-1:0] imem_align(input logic [ADDR_W-1:0] addr);
    return addr & {{(ADDR_W-2){1'b1}}, 2'b00};
  endfunction

  // True for the last word of the address space (no successor to prefetch).
  function automatic logic imem_is_top_word(input logic [ADDR_W-1:0] addr);
    return &addr[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// -----------------------------------------------------------------------------
// imem_responder_if
// Groups the fetch-side handshake and the backing-bus signals of the responder.
//   if2mem_s    : fetch request (addr, req)
//   mem2if_s    : fetch response (r_data, ack)
//   imem_flush_s: buffer invalidate (fence.i / redirect)
//   bus_req_s   : backing bus request, held until bus_ack_s
//   bus_addr_s  : word-aligned bus address
//   bus_ack_s   : one-cycle bus response strobe
//   bus_rdata_s : bus read data, qualified by bus_ack_s
// Modports: slave = the responder, master = fetch stage + bus environment.
// -----------------------------------------------------------------------------
interface imem_responder_if;
  import imem_responder_pkg::*;

  type_if2imem_s     if2mem_s;
  type_imem2if_s     mem2if_s;
  logic              imem_flush_s;
  logic              bus_req_s;
  logic [ADDR_W-1:0] bus_addr_s;
  logic              bus_ack_s;
  logic [DATA_W-1:0] bus_rdata_s;

  modport slave (
    input  if2mem_s, imem_flush_s, bus_ack_s, bus_rdata_s,
    output mem2if_s, bus_req_s, bus_addr_s
  );

  modport master (
    output if2mem_s, imem_flush_s, bus_ack_s, bus_rdata_s,
    input  mem2if_s, bus_req_s, bus_addr_s
  );

endinterface

// File: rtl/imem_resp_buf.sv
// -----------------------------------------------------------------------------
// imem_resp_buf
// One-entry tagged response buffer with hit comparator.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   lookup_req_s   : fetch request qualifier for the hit
//   lookup_addr_s  : word-aligned fetch address
//   inval_s        : invalidate (highest priority after reset)
//   fill_s         : load tag/data and mark valid
//   fill_tag_s     : tag of the filled word (in-flight bus address)
//   fill_data_s    : filled word
//   consume_s      : entry was acked this cycle, drop it
//   hit_s          : request matches a valid entry (combinational)
//   data_s         : stored word (registered)
// A fill beats a same-cycle consume so a new word is not lost when the old
// entry is acked in the cycle its successor arrives.
// -----------------------------------------------------------------------------
module imem_resp_buf
  import imem_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_req_s,
  input  logic [ADDR_W-1:0] lookup_addr_s,
  input  logic              inval_s,
  input  logic              fill_s,
  input  logic [ADDR_W-1:0] fill_tag_s,
  input  logic [DATA_W-1:0] fill_data_s,
  input  logic              consume_s,
  output logic              hit_s,
  output logic [DATA_W-1:0] data_s
);

  logic              valid_r;
  logic [ADDR_W-1:0] tag_r;
  logic [DATA_W-1:0] data_r;

  // Entry state update: reset > invalidate > fill > consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      tag_r   <= {ADDR_W{1'b0}};
      data_r  <= {DATA_W{1'b0}};
    end else if (inval_s) begin
      valid_r <= 1'b0;
    end else if (fill_s) begin
      valid_r <= 1'b1;
      tag_r   <= fill_tag_s;
      data_r  <= fill_data_s;
    end else if (consume_s) begin
      valid_r <= 1'b0;
    end
  end

  // Hit comparator and data output.
  always_comb begin
    hit_s  = lookup_req_s & valid_r & (tag_r == lookup_addr_s);
    data_s = data_r;
  end

endmodule

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
// Responder end of the IF<->IMEM interface. Fetch requests hit a one-entry
// tagged buffer; misses are serviced over a single-outstanding req/ack bus.
// Ports:
//   clk   : clock, all state on posedge
//   rst   : synchronous reset, active-high
//   imem  : imem_responder_if.slave (fetch req/resp, flush, backing bus)
// Build option: `define IMEM_PREFETCH_EN adds a sequential prefetcher that
// launches A+4 after each ack of A (PF_WAIT state). Without it PF_WAIT is
// never entered and the FSM waits in IDLE for the next miss.
// Fetch ack is a combinational hit on the buffer; r_data comes straight from
// the buffer register, so nothing on the bus side reaches the fetch outputs
// combinationally.
// -----------------------------------------------------------------------------
module imem_responder
  import imem_responder_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  imem_responder_if.slave imem
);

  type_imem_resp_state_e state_r;
  logic                  bus_req_r;
  logic [ADDR_W-1:0]     bus_addr_r;
  logic                  discard_r;   // flush hit the in-flight transfer

  logic [ADDR_W-1:0]     a_al_s;
  logic                  hit_s;
  logic                  ack_s;
  logic                  fill_s;
  logic                  addr_moved_s;
  logic [DATA_W-1:0]     buf_data_s;

  // Fetch-side decode: aligned address, ack, and bus fill qualification.
  always_comb begin
    a_al_s       = imem_align(imem.if2mem_s.addr);
    ack_s        = hit_s & ~imem.imem_flush_s;
    addr_moved_s = imem.if2mem_s.req & (a_al_s != bus_addr_r);
    if (state_r != IMEM_IDLE) begin
      // A bus_ack in IDLE is a leftover from before reset and is dropped.
      fill_s = imem.bus_ack_s & ~discard_r;
    end else begin
      fill_s = 1'b0;
    end
  end

  imem_resp_buf u_buf (
    .clk           (clk),
    .rst           (rst),
    .lookup_req_s  (imem.if2mem_s.req),
    .lookup_addr_s (a_al_s),
    .inval_s       (imem.imem_flush_s),
    .fill_s        (fill_s),
    .fill_tag_s    (bus_addr_r),
    .fill_data_s   (imem.bus_rdata_s),
    .consume_s     (ack_s),
    .hit_s         (hit_s),
    .data_s        (buf_data_s)
  );

  // Responder FSM and backing-bus driver.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IMEM_IDLE;
      bus_req_r  <= 1'b0;
      bus_addr_r <= {ADDR_W{1'b0}};
      discard_r  <= 1'b0;
    end else begin
      case (state_r)
        IMEM_IDLE: begin
          if (imem.imem_flush_s) begin
            state_r <= IMEM_IDLE;
          end else if (ack_s) begin
`ifdef IMEM_PREFETCH_EN
            if (!imem_is_top_word(a_al_s)) begin
              bus_req_r  <= 1'b1;
              bus_addr_r <= a_al_s + IMEM_WORD_STRIDE;
              state_r    <= IMEM_PF_WAIT;
            end
`endif
          end else if (imem.if2mem_s.req) begin
            // Not flushed and no hit: this is a demand miss.
            bus_req_r  <= 1'b1;
            bus_addr_r <= a_al_s;
            state_r    <= IMEM_DEMAND;
          end
        end

`ifdef IMEM_PREFETCH_EN
        IMEM_DEMAND, IMEM_PF_WAIT: begin
`else
        IMEM_DEMAND: begin
`endif
          if (imem.bus_ack_s) begin
            // Same-cycle flush is handled by the buffer's invalidate priority.
            bus_req_r <= 1'b0;
            discard_r <= 1'b0;
            state_r   <= IMEM_IDLE;
          end else if (imem.imem_flush_s) begin
            discard_r <= 1'b1;
            state_r   <= IMEM_DRAIN;
          end else if (addr_moved_s) begin
            // Transfer is never aborted; let it land under its own tag.
            state_r <= IMEM_DRAIN;
          end
        end

        IMEM_DRAIN: begin
          if (imem.bus_ack_s) begin
            bus_req_r <= 1'b0;
            discard_r <= 1'b0;
            state_r   <= IMEM_IDLE;
          end else if (imem.imem_flush_s) begin
            discard_r <= 1'b1;
          end
        end

        default: begin
          bus_req_r <= 1'b0;
          discard_r <= 1'b0;
          state_r   <= IMEM_IDLE;
        end
      endcase
    end
  end

  // Drive interface outputs.
  always_comb begin
    imem.mem2if_s.ack    = ack_s;
    imem.mem2if_s.r_data = buf_data_s;
    imem.bus_req_s       = bus_req_r;
    imem.bus_addr_s      = bus_addr_r;
  end

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
// Directed bench for imem_responder: fetch stimulus from the main process,
// a wait-state-programmable bus responder in a second process, and
// hand-computed expectations checked at the falling clock edge.
// -----------------------------------------------------------------------------
module tb_imem_responder;
  import imem_responder_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  // Bus responder controls (written by the main process only)
  int   bus_wait;
  logic bus_auto;
  logic man_ack;
  int   bus_cnt;

  logic saw_ack;

  imem_responder_if imem_if ();

  imem_responder dut (
    .clk  (clk),
    .rst  (rst),
    .imem (imem_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0000_0013;
      32'h0000_0200: return 32'h0000_0293;
      32'h0000_0300: return 32'h0010_0093;
      32'h0000_0400: return 32'h0020_0113;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic flush);
    imem_if.if2mem_s.req  = req;
    imem_if.if2mem_s.addr = addr;
    imem_if.imem_flush_s  = flush;
  endtask

  // Bus responder: acks after bus_wait waiting cycles, or follows man_ack.
  initial begin
    imem_if.bus_ack_s   = 1'b0;
    imem_if.bus_rdata_s = 32'h0;
    bus_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!bus_auto) begin
        imem_if.bus_ack_s = man_ack;
        bus_cnt = 0;
      end else if (imem_if.bus_req_s && bus_cnt == bus_wait) begin
        imem_if.bus_ack_s = 1'b1;
        bus_cnt = 0;
      end else if (imem_if.bus_req_s) begin
        imem_if.bus_ack_s = 1'b0;
        bus_cnt++;
      end else begin
        imem_if.bus_ack_s = 1'b0;
        bus_cnt = 0;
      end
      imem_if.bus_rdata_s = mem_word(imem_if.bus_addr_s);
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus_auto = 1'b1;
    bus_wait = 0;
    man_ack  = 1'b0;
    drive(1'b0, 32'h0, 1'b0);

    // Reset state
    next_cycle(); next_cycle(); at_sample();
    check("rst_ack",      imem_if.mem2if_s.ack,    64'h0);
    check("rst_rdata",    imem_if.mem2if_s.r_data, 64'h0);
    check("rst_bus_req",  imem_if.bus_req_s,       64'h0);
    check("rst_bus_addr", imem_if.bus_addr_s,      64'h0);
    check("rst_state",    64'(dut.state_r),        64'(IMEM_IDLE));
    next_cycle(); rst = 1'b0;

    // 1: zero-wait miss on 0x100
    bus_wait = 0;
    next_cycle(); drive(1'b1, 32'h100, 1'b0); at_sample();
    check("t1_T_bus_req", imem_if.bus_req_s, 64'h0);
    next_cycle(); at_sample();
    check("t1_T1_bus_req",  imem_if.bus_req_s,    64'h1);
    check("t1_T1_bus_addr", imem_if.bus_addr_s,   64'h100);
    check("t1_T1_ack",      imem_if.mem2if_s.ack, 64'h0);
    next_cycle(); at_sample();
    check("t1_T2_ack",   imem_if.mem2if_s.ack,    64'h1);
    check("t1_T2_rdata", imem_if.mem2if_s.r_data, 64'h13);
    next_cycle(); at_sample();
    check("t1_single_ack", imem_if.mem2if_s.ack, 64'h0);
    next_cycle(); drive(1'b0, 32'h0, 1'b0);
    next_cycle(); drive(1'b0, 32'h0, 1'b1);
    next_cycle(); drive(1'b0, 32'h0, 1'b0);

    // 2: 3 wait states, address moves 0x100 -> 0x200 mid-flight
    bus_wait = 3;
    next_cycle(); drive(1'b1, 32'h100, 1'b0);
    next_cycle();
    next_cycle(); drive(1'b1, 32'h200, 1'b0);
    saw_ack = 1'b0;
    for (int i = 3; i <= 9; i++) begin
      next_cycle(); at_sample();
      if (imem_if.mem2if_s.ack) saw_ack = 1'b1;
      if (i == 3) check("t2_drain", 64'(dut.state_r), 64'(IMEM_DRAIN));
      if (i == 6) begin
        check("t2_bus_req2",  imem_if.bus_req_s,  64'h1);
        check("t2_bus_addr2", imem_if.bus_addr_s, 64'h200);
      end
    end
    check("t2_no_early_ack", saw_ack, 64'h0);
    next_cycle(); at_sample();
    check("t2_ack",   imem_if.mem2if_s.ack,    64'h1);
    check("t2_rdata", imem_if.mem2if_s.r_data, 64'h293);
    next_cycle(); drive(1'b0, 32'h0, 1'b0);

    // 3: req dropped during fill of 0x300, later buffer hit
    bus_wait = 1;
    next_cycle(); drive(1'b1, 32'h300, 1'b0);
    next_cycle(); drive(1'b0, 32'h300, 1'b0); at_sample();
    check("t3_bus_req", imem_if.bus_req_s, 64'h1);
    next_cycle();
    next_cycle(); at_sample();
    check("t3_kill_noack", imem_if.mem2if_s.ack, 64'h0);
    next_cycle(); drive(1'b1, 32'h300, 1'b0); at_sample();
    check("t3_hit_ack",     imem_if.mem2if_s.ack,    64'h1);
    check("t3_hit_rdata",   imem_if.mem2if_s.r_data, 64'h0010_0093);
    check("t3_hit_bus_req", imem_if.bus_req_s,       64'h0);
    next_cycle(); drive(1'b0, 32'h0, 1'b0); at_sample();
    check("t3_no_refetch", imem_if.bus_req_s, 64'h0);

    // 4: flush in the same cycle as bus_ack for 0x400
    bus_wait = 2;
    next_cycle(); drive(1'b1, 32'h400, 1'b0);
    next_cycle();
    next_cycle();
    next_cycle(); drive(1'b1, 32'h400, 1'b1); at_sample();
    check("t4_bus_ack_aligned", imem_if.bus_ack_s,    64'h1);
    check("t4_flush_noack",     imem_if.mem2if_s.ack, 64'h0);
    next_cycle(); drive(1'b1, 32'h400, 1'b0); at_sample();
    saw_ack = imem_if.mem2if_s.ack;
    for (int i = 5; i <= 7; i++) begin
      next_cycle(); at_sample();
      if (imem_if.mem2if_s.ack) saw_ack = 1'b1;
      if (i == 5) begin
        check("t4_refetch_req",  imem_if.bus_req_s,  64'h1);
        check("t4_refetch_addr", imem_if.bus_addr_s, 64'h400);
      end
    end
    check("t4_no_early_ack", saw_ack, 64'h0);
    next_cycle(); at_sample();
    check("t4_ack",   imem_if.mem2if_s.ack,    64'h1);
    check("t4_rdata", imem_if.mem2if_s.r_data, 64'h0020_0113);
    next_cycle(); drive(1'b0, 32'h0, 1'b0);

`ifdef IMEM_PREFETCH_EN
    // 5: sequential stream with prefetch, then top word
    bus_wait = 0;
    next_cycle(); drive(1'b1, 32'h0, 1'b0);
    next_cycle(); at_sample();
    check("t5_addr0", imem_if.bus_addr_s, 64'h0);
    next_cycle(); at_sample();
    check("t5_ack0", imem_if.mem2if_s.ack, 64'h1);
    next_cycle(); drive(1'b1, 32'h4, 1'b0); at_sample();
    check("t5_req4",  imem_if.bus_req_s,    64'h1);
    check("t5_addr4", imem_if.bus_addr_s,   64'h4);
    check("t5_gap4",  imem_if.mem2if_s.ack, 64'h0);
    next_cycle(); at_sample();
    check("t5_ack4",   imem_if.mem2if_s.ack,    64'h1);
    check("t5_rdata4", imem_if.mem2if_s.r_data, 64'h5A5A_0004);
    next_cycle(); drive(1'b1, 32'h8, 1'b0); at_sample();
    check("t5_addr8", imem_if.bus_addr_s,   64'h8);
    check("t5_gap8",  imem_if.mem2if_s.ack, 64'h0);
    next_cycle(); at_sample();
    check("t5_ack8", imem_if.mem2if_s.ack, 64'h1);
    next_cycle(); drive(1'b1, 32'hFFFF_FFFC, 1'b0);
    next_cycle();
    next_cycle(); at_sample();
    check("t5_addr_top", imem_if.bus_addr_s, 64'hFFFF_FFFC);
    next_cycle(); at_sample();
    check("t5_ack_top", imem_if.mem2if_s.ack, 64'h1);
    next_cycle(); drive(1'b0, 32'h0, 1'b0); at_sample();
    check("t5_no_pf_top", imem_if.bus_req_s, 64'h0);
`endif

    // 6: reset while DEMAND, late bus_ack ignored
    bus_wait = 5;
    next_cycle(); drive(1'b1, 32'h500, 1'b0);
    next_cycle(); at_sample();
    check("t6_demand_req", imem_if.bus_req_s, 64'h1);
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0; bus_auto = 1'b0; drive(1'b0, 32'h0, 1'b0); at_sample();
    check("t6_ack",      imem_if.mem2if_s.ack,    64'h0);
    check("t6_rdata",    imem_if.mem2if_s.r_data, 64'h0);
    check("t6_bus_req",  imem_if.bus_req_s,       64'h0);
    check("t6_bus_addr", imem_if.bus_addr_s,      64'h0);
    check("t6_state",    64'(dut.state_r),        64'(IMEM_IDLE));
    next_cycle(); man_ack = 1'b1; drive(1'b1, 32'h0, 1'b0); at_sample();
    check("t6_late_ack_cycle", imem_if.mem2if_s.ack, 64'h0);
    next_cycle(); man_ack = 1'b0; bus_auto = 1'b1; bus_wait = 0; at_sample();
    check("t6_late_ack_ignored", imem_if.mem2if_s.ack, 64'h0);
    check("t6_miss_launch",      imem_if.bus_req_s,    64'h1);
    next_cycle(); at_sample();
    check("t6_ack_after",   imem_if.mem2if_s.ack,    64'h1);
    check("t6_rdata_after", imem_if.mem2if_s.r_data, 64'h5A5A_0000);
    next_cycle(); drive(1'b0, 32'h0, 1'b0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
